// File: rtl/state_frame_ctrl.sv
// Call/return frame controller in front of the 17-bit state register file.
// Define STATE_END_MARK_EN to append an end-marker entry after every completed return.
module state_frame_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int POS_WIDTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              call_valid,
  input  logic [POS_WIDTH-1:0]              call_pos,
  output logic                              call_ready,
  input  logic                              ret_valid,
  output logic                              ret_ready,
  output logic                              ret_done,
  output logic [POS_WIDTH-1:0]              ret_pos,
  output logic                              underflow,
  output logic                              full,
  output logic [ADDR_WIDTH-1:0]             cur_addr,
  output logic [ADDR_WIDTH-1:0]             depth,
  output logic                              we,
  output logic [POS_WIDTH+ADDR_WIDTH:0]     w_data,
  output logic                              ran_re,
  output logic [ADDR_WIDTH-1:0]             ran_r_addr,
  input  logic [POS_WIDTH+ADDR_WIDTH:0]     ran_r_data
);

  localparam int ENTRY_W = POS_WIDTH + ADDR_WIDTH + 1;

`ifdef STATE_END_MARK_EN
  typedef enum logic [1:0] {IDLE, RD, WAIT, MARK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WAIT} state_t;
`endif

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    we_q;
  logic [ENTRY_W-1:0]      w_data_q;
  logic                    idle;
  logic                    call_fire;
  logic                    ret_fire;
  logic                    rd_start;
  logic [POS_WIDTH-1:0]    rd_pos;
  logic [ADDR_WIDTH-1:0]   rd_parent;
  logic                    unused_end_flag;

  assign idle       = (state == IDLE);
  assign full       = (wr_ptr == '1);
  assign call_ready = rst_n & idle & ~full & ~ret_valid;
  assign ret_ready  = idle;
  assign call_fire  = call_valid & call_ready;
  assign ret_fire   = ret_valid & idle;
  assign rd_start   = ret_fire & (depth != '0);

  assign rd_pos          = ran_r_data[ENTRY_W-1 -: POS_WIDTH];
  assign rd_parent       = ran_r_data[ADDR_WIDTH:1];
  // The end flag of a call entry is always zero; nothing downstream needs it.
  assign unused_end_flag = ran_r_data[0];

  // Call writes bypass the register so the entry lands in the handshake cycle.
  assign we     = call_fire | we_q;
  assign w_data = call_fire ? {call_pos, cur_addr, 1'b0} : w_data_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rd_start) state_nxt = RD;
      RD:   state_nxt = WAIT;
`ifdef STATE_END_MARK_EN
      WAIT: state_nxt = MARK;
      MARK: state_nxt = IDLE;
`else
      WAIT: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STATE_END_MARK_EN
  logic [POS_WIDTH-1:0]  pos_q;
  logic [ADDR_WIDTH-1:0] parent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= '0;
      parent_q <= '0;
      w_data_q <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state == WAIT) begin
        pos_q    <= rd_pos;
        parent_q <= rd_parent;
        w_data_q <= {rd_pos, rd_parent, 1'b1};
        // The last slot is reserved; never let the marker wrap wr_ptr.
        we_q     <= (wr_ptr != '1);
      end
    end
  end
`else
  assign we_q     = 1'b0;
  assign w_data_q = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cur_addr   <= '1;
      depth      <= '0;
      ret_done   <= 1'b0;
      ret_pos    <= '0;
      underflow  <= 1'b0;
      ran_re     <= 1'b0;
      ran_r_addr <= '0;
    end else begin
      state     <= state_nxt;
      ret_done  <= 1'b0;
      underflow <= ret_fire & (depth == '0);
      ran_re    <= rd_start;
      if (rd_start) ran_r_addr <= cur_addr;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (call_fire) begin
        cur_addr <= wr_ptr;
        depth    <= depth + 1'b1;
      end else if (state == WAIT) begin
        ret_done <= 1'b1;
        ret_pos  <= rd_pos;
        cur_addr <= rd_parent;
        depth    <= depth - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_state_frame_ctrl.sv
// Directed bench for state_frame_ctrl with a behavioural register-file model.
// Expectations follow STATE_END_MARK_EN the same way the design does.
module tb_state_frame_ctrl;

  localparam int AW = 12;
  localparam int PW = 4;
  localparam int EW = PW + AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          call_valid;
  logic [PW-1:0] call_pos;
  logic          call_ready;
  logic          ret_valid;
  logic          ret_ready;
  logic          ret_done;
  logic [PW-1:0] ret_pos;
  logic          underflow;
  logic          full;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] depth;
  logic          we;
  logic [EW-1:0] w_data;
  logic          ran_re;
  logic [AW-1:0] ran_r_addr;
  logic [EW-1:0] ran_r_data;

  state_frame_ctrl #(.ADDR_WIDTH(AW), .POS_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_valid(call_valid), .call_pos(call_pos), .call_ready(call_ready),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_done(ret_done),
    .ret_pos(ret_pos), .underflow(underflow), .full(full),
    .cur_addr(cur_addr), .depth(depth), .we(we), .w_data(w_data),
    .ran_re(ran_re), .ran_r_addr(ran_r_addr), .ran_r_data(ran_r_data)
  );

  always #5 clk = ~clk;

  // Register file model: sequential write port, one-cycle random read.
  logic [EW-1:0] tb_mem [0:(1<<AW)-1];
  logic [AW-1:0] tb_wp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_wp      <= '0;
      ran_r_data <= '0;
    end else begin
      if (we) begin
        tb_mem[tb_wp] <= w_data;
        tb_wp         <= tb_wp + 1'b1;
      end
      if (ran_re) ran_r_data <= tb_mem[ran_r_addr];
    end
  end

  typedef struct packed {
    logic          cr;
    logic          rr;
    logic          we;
    logic [EW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          done;
    logic [PW-1:0] rpos;
    logic          uf;
    logic          full;
    logic [AW-1:0] cur;
    logic [AW-1:0] depth;
  } out_t;

  typedef struct {
    logic          cv;
    logic [PW-1:0] cp;
    logic          rv;
    out_t          exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic out_t o(input logic cr, input logic rr, input logic w,
                             input logic [EW-1:0] wd, input logic re,
                             input logic [AW-1:0] ra, input logic dn,
                             input logic [PW-1:0] rp, input logic uf,
                             input logic fl, input logic [AW-1:0] cu,
                             input logic [AW-1:0] dp);
    return {cr, rr, w, wd, re, ra, dn, rp, uf, fl, cu, dp};
  endfunction

  function automatic out_t obs();
    return {call_ready, ret_ready, we, w_data, ran_re, ran_r_addr, ret_done,
            ret_pos, underflow, full, cur_addr, depth};
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    call_valid = 1'b0;
    call_pos   = '0;
    ret_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  out_t rst_vec;
  vec_t vecs [7];
  bit   seen_done, seen_we, early_ready, got_ready;
  logic [PW-1:0] cap_pos;
  logic [AW-1:0] cap_cur, cap_dep, exp_cur;

  initial begin
    rst_vec = o(0, 1, 0, 17'h0, 0, 12'h000, 0, 4'h0, 0, 0, 12'hFFF, 12'h000);

    vecs[0] = '{cv:1'b1, cp:4'd3, rv:1'b0, exp:o(1,1,1,17'h07FFE,0,12'h000,0,4'h0,0,0,12'hFFF,12'd0)};
    vecs[1] = '{cv:1'b1, cp:4'd7, rv:1'b0, exp:o(1,1,1,17'h0E000,0,12'h000,0,4'h0,0,0,12'h000,12'd1)};
    vecs[2] = '{cv:1'b0, cp:4'd0, rv:1'b1, exp:o(0,1,0,17'h00000,0,12'h000,0,4'h0,0,0,12'h001,12'd2)};
    vecs[3] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(0,0,0,17'h00000,1,12'h001,0,4'h0,0,0,12'h001,12'd2)};
    vecs[4] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(0,0,0,17'h00000,0,12'h001,0,4'h0,0,0,12'h001,12'd2)};
`ifdef STATE_END_MARK_EN
    vecs[5] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(0,0,1,17'h0E001,0,12'h001,1,4'd7,0,0,12'h000,12'd1)};
    vecs[6] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(1,1,0,17'h0E001,0,12'h001,0,4'd7,0,0,12'h000,12'd1)};
`else
    vecs[5] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(1,1,0,17'h00000,0,12'h001,1,4'd7,0,0,12'h000,12'd1)};
    vecs[6] = '{cv:1'b0, cp:4'd0, rv:1'b0, exp:o(1,1,0,17'h00000,0,12'h001,0,4'd7,0,0,12'h000,12'd1)};
`endif

    // Reset values, then the first call of the bench.
    rst_n = 1'b0; call_valid = 1'b0; call_pos = '0; ret_valid = 1'b0;
    @(negedge clk); #1;
    check_out("reset_values", obs(), rst_vec);
    rst_n = 1'b1;
    @(negedge clk);
    call_valid = 1'b1; call_pos = 4'd5; #1;
    check_out("call5_write", obs(), o(1,1,1,17'h0BFFE,0,12'h000,0,4'h0,0,0,12'hFFF,12'd0));
    @(negedge clk);
    call_valid = 1'b0; #1;
    check_out("call5_after", obs(), o(1,1,0,17'h0,0,12'h000,0,4'h0,0,0,12'h000,12'd1));

    // Two calls and a return, one table row per cycle.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      call_valid = vecs[i].cv; call_pos = vecs[i].cp; ret_valid = vecs[i].rv;
      #1;
      check_out($sformatf("ret_seq_row%0d", i), obs(), vecs[i].exp);
    end
`ifdef STATE_END_MARK_EN
    check_val("mark_entry2", 32'(tb_mem[2]), 32'h0E001);
    check_val("wr_count_mark", 32'(tb_wp), 32'd3);
`else
    check_val("wr_count", 32'(tb_wp), 32'd2);
`endif

    // Return at depth 0: only an underflow pulse.
    do_reset();
    @(negedge clk); ret_valid = 1'b1; #1;
    check_out("uf_accept", obs(), o(0,1,0,17'h0,0,12'h000,0,4'h0,0,0,12'hFFF,12'd0));
    @(negedge clk); ret_valid = 1'b0; #1;
    check_out("uf_pulse", obs(), o(1,1,0,17'h0,0,12'h000,0,4'h0,1,0,12'hFFF,12'd0));
    @(negedge clk); #1;
    check_out("uf_clear", obs(), o(1,1,0,17'h0,0,12'h000,0,4'h0,0,0,12'hFFF,12'd0));

    // Simultaneous call and return at depth 1: the return wins.
    do_reset();
    @(negedge clk); call_valid = 1'b1; call_pos = 4'd5;
    @(negedge clk); call_pos = 4'd9; ret_valid = 1'b1; #1;
    check_out("collide_accept", obs(), o(0,1,0,17'h0,0,12'h000,0,4'h0,0,0,12'h000,12'd1));
    @(negedge clk); ret_valid = 1'b0;
    seen_done = 0; early_ready = 0; got_ready = 0;
    exp_cur = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ret_done) seen_done = 1;
      if (call_ready) begin
        if (!seen_done) early_ready = 1;
        got_ready = 1;
        check_val("collide_wdata", 32'(w_data), 32'h13FFE);
        exp_cur = tb_wp;
        break;
      end
      @(negedge clk);
    end
    check_val("collide_order", {30'd0, got_ready, early_ready}, 32'd2);
    @(negedge clk); call_valid = 1'b0; #1;
`ifdef STATE_END_MARK_EN
    check_val("collide_cur", 32'(cur_addr), 32'd2);
`else
    check_val("collide_cur", 32'(cur_addr), 32'd1);
`endif
    check_val("collide_dep", 32'(depth), 32'd1);

    // Fill to the reserved slot, then return with the marker suppressed.
    do_reset();
    got_ready = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (full) begin
        got_ready = 1;
        break;
      end
      call_valid = 1'b1;
      call_pos   = tb_wp[PW-1:0];
    end
    #1;
    check_val("fill_reached", {31'd0, got_ready}, 32'd1);
    check_out("fill_state", obs(), o(0,1,0,17'h0,0,12'h000,0,4'h0,0,1,12'd4094,12'd4095));
    @(negedge clk);
    call_valid = 1'b0; ret_valid = 1'b1;
    @(negedge clk);
    ret_valid = 1'b0;
    seen_done = 0; seen_we = 0; cap_pos = '0; cap_cur = '0; cap_dep = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (we) seen_we = 1;
      if (ret_done) begin
        seen_done = 1; cap_pos = ret_pos; cap_cur = cur_addr; cap_dep = depth;
      end
      @(negedge clk);
    end
    check_val("full_ret_done", {30'd0, seen_done, seen_we}, 32'd2);
    check_val("full_ret_frame", {8'd0, cap_pos, cap_cur, cap_dep}, {8'd0, 4'd14, 12'd4093, 12'd4094});
    check_val("full_still", {31'd0, full}, 32'd1);

    // Reset while waiting for read data aborts the return.
    do_reset();
    @(negedge clk); call_valid = 1'b1; call_pos = 4'd1;
    @(negedge clk); call_pos = 4'd2;
    @(negedge clk); call_valid = 1'b0; ret_valid = 1'b1;
    @(negedge clk); ret_valid = 1'b0;
    @(negedge clk); #1;
    check_out("abort_wait", obs(), o(0,0,0,17'h0,0,12'h001,0,4'h0,0,0,12'h001,12'd2));
    rst_n = 1'b0; #1;
    check_out("abort_reset", obs(), rst_vec);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ret_done) seen_done = 1;
      @(negedge clk);
    end
    check_val("abort_no_done", {31'd0, seen_done}, 32'd0);
    #1;
    check_out("abort_after", obs(), o(1,1,0,17'h0,0,12'h000,0,4'h0,0,0,12'hFFF,12'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/state_frame_ctrl.md
# state_frame_ctrl

Call/return frame controller that sits directly upstream of the 17-bit state register file. On each call it appends a state entry {call position, parent entry address, end flag}. On each return it random-reads the current entry to recover the caller's position and parent address, then unwinds the frame pointer. It optionally appends an end-marker entry. It drives the register file's write port and random-read port only, and never issues sequential reads.

## Interface
Parameters:
- ADDR_WIDTH, 12, entry address width; entry count is 2^ADDR_WIDTH.
- POS_WIDTH, 4, call-position width; entry width is POS_WIDTH+ADDR_WIDTH+1 = 17.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- call_valid  in  1  call request.
- call_pos  in  POS_WIDTH  position of the calling site.
- call_ready  out  1  call accepted this cycle when high with call_valid.
- ret_valid  in  1  return request.
- ret_ready  out  1  return accepted this cycle when high with ret_valid.
- ret_done  out  1  one-cycle pulse: return finished, ret_pos valid.
- ret_pos  out  POS_WIDTH  caller position recovered by the return.
- underflow  out  1  one-cycle pulse: return accepted at depth 0.
- full  out  1  high when wr_ptr == 2^ADDR_WIDTH - 1, i.e. one slot remains reserved.
- cur_addr  out  ADDR_WIDTH  address of the active frame; all-ones means root.
- depth  out  ADDR_WIDTH  number of open frames.
- we  out  1  register-file write enable.
- w_data  out  17  {pos, parent_addr, end_flag}, MSB first.
- ran_re  out  1  register-file random-read enable.
- ran_r_addr  out  ADDR_WIDTH  random-read address.
- ran_r_data  in  17  random-read data, valid one cycle after ran_re.

## Operation
- Internal wr_ptr mirrors the register file's sequential write address. It increments on every we.
- FSM states: IDLE, RD, WAIT, MARK.
- Transition IDLE→RD on an accepted return at depth != 0.
- Transition RD→WAIT unconditionally.
- Transition WAIT→MARK when the end mark is enabled; otherwise WAIT→IDLE.
- Transition MARK→IDLE unconditionally.
- Call handshake:
  - call_ready = (state==IDLE) & !full & !ret_valid.
  - On an accepted call, the same cycle drives we=1 and w_data={call_pos, cur_addr, 0}.
  - Next edge: cur_addr<=wr_ptr, wr_ptr++, depth++.
- Return handshake:
  - ret_ready = (state==IDLE). A return has priority over a simultaneous call; that call waits.
  - RD cycle: ran_re=1, ran_r_addr=cur_addr.
  - WAIT cycle: capture ran_r_data into pos_q and parent_q.
  - Completion: ret_done=1, ret_pos=pos_q, cur_addr<=parent_q, depth--.
- Return at depth 0: the request is accepted, underflow pulses the next cycle, and there is no read and no state change.
- End-marker write in MARK: w_data={pos_q, parent_q, 1}. The write is suppressed if wr_ptr == all-ones.
- ADDR_WIDTH arithmetic wraps modulo 2^ADDR_WIDTH. The full output prevents wr_ptr from wrapping in practice.
- Reset mid-return aborts it: FSM returns to IDLE and no ret_done is produced.

## Timing
- Reset values:
  - call_ready=0, ret_ready=1, ret_done=0, ret_pos=0, underflow=0, full=0.
  - cur_addr=all-ones, depth=0, we=0, w_data=0, ran_re=0, ran_r_addr=0.
  - wr_ptr=0, FSM=IDLE.
- Call: the write happens in the handshake cycle T. cur_addr and depth update at T+1. A new call may be accepted every cycle.
- Return accepted at T:
  - ran_re at T+1.
  - Data captured at T+2.
  - ret_done and cur_addr update at T+3 (from MARK or WAIT).
  - ret_ready is high again at T+3 without the end mark, or T+4 with it.
- ret_done, ret_pos, underflow, we, w_data, ran_re and ran_r_addr are all registered outputs. The exception is the call-path we/w_data, which is combinational from call_valid in IDLE.

## Configuration
- STATE_END_MARK_EN defined:
  - The MARK state exists.
  - Each completed return appends an end entry (end_flag=1) and increments wr_ptr.
  - The return occupies 4 cycles.
- STATE_END_MARK_EN undefined:
  - No MARK state and no end entries.
  - The return occupies 3 cycles.
  - ret_done timing (T+3) is unchanged.

## Test plan
- Reset then call pos=5 → we=1 with w_data={5, 0xFFF, 0}; next cycle cur_addr=0, depth=1.
- Calls pos=3 then pos=7, then return → ran_re with addr=1; ret_done at T+3 with ret_pos=7, cur_addr=0, depth=1. With STATE_END_MARK_EN, an extra write of {7, 0, 1} goes to entry 2.
- Return at depth 0 → underflow pulse one cycle; cur_addr stays 0xFFF; no ran_re, no we.
- call_valid and ret_valid both high at depth 1 → return serviced first, call_ready=0. The call is then accepted and written with parent=0xFFF.
- Fill to wr_ptr=4095 → full=1 and call_ready=0; a return still completes; the end-mark write is suppressed.
- Assert rst_n low during WAIT → all outputs return to reset values; no ret_done observed afterward.
